// File: rtl/cache_ahb_refill_out.sv
// AHB read-burst master that refills one cache line, either critical-word-first (WRAP) or
// line-aligned (INCR). Data phase n overlaps address phase n+1; at most one data phase is open.
module cache_ahb_refill_out #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int WRAP_EN    = 1
) (
  input  logic                       i_hclk,
  input  logic                       i_hnreset,
  input  logic                       i_req,
  input  logic [ADDR_W-3:0]          i_addr,
  output logic                       o_busy,
  output logic [31:0]                o_rdata,
  output logic                       o_rvalid,
  output logic [((LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1)-1:0] o_ridx,
  output logic                       o_done,
  output logic                       o_err,
  output logic [ADDR_W-1:0]          o_haddr,
  output logic [1:0]                 o_htrans,
  output logic [2:0]                 o_hburst,
  output logic [2:0]                 o_hsize,
  output logic                       o_hwrite,
  output logic [3:0]                 o_hprot,
  output logic                       o_hmastlock,
  output logic [31:0]                o_hwdata,
  input  logic                       i_hready,
  input  logic                       i_hresp,
  input  logic [31:0]                i_hrdata
);
  localparam int IW   = $clog2(LINE_WORDS);
  localparam int IDXW = (IW == 0) ? 1 : IW;
  localparam int CW   = IW + 1;
  localparam int WAW  = ADDR_W - 2;
  localparam logic [WAW-1:0] IDX_MASK = WAW'(LINE_WORDS - 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(LINE_WORDS - 1);
  localparam logic [2:0] HBURST =
    (LINE_WORDS == 1) ? 3'h0 :
    (LINE_WORDS == 4) ? ((WRAP_EN != 0) ? 3'h2 : 3'h3) :
    (LINE_WORDS == 8) ? ((WRAP_EN != 0) ? 3'h4 : 3'h5) :
                        ((WRAP_EN != 0) ? 3'h6 : 3'h7);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_e;

  state_e          state_q, state_d;
  logic [WAW-1:0]  base_q, base_d;
  logic [CW-1:0]   acnt_q, acnt_d;
  logic [CW-1:0]   dcnt_q, dcnt_d;
  logic            data_act;
  logic            rvalid;
  logic [IDXW-1:0] ridx;

  // Word n of the burst: upper bits held, index bits advance modulo the line size.
  // For INCR the base is line-aligned, so this is a plain increment.
  function automatic logic [WAW-1:0] word_at(input logic [WAW-1:0] base, input logic [CW-1:0] n);
    logic [WAW-1:0] sum;
    sum = base + WAW'(n);
    return (base & ~IDX_MASK) | (sum & IDX_MASK);
  endfunction

  // Handshake: every AHB phase advances only in a cycle with i_hready=1; o_rvalid is a
  // one-cycle strobe with no back-pressure, and o_done/o_err form a one-cycle completion pulse.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      acnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      acnt_q  <= acnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // A data phase is open whenever more address phases were accepted than data phases finished.
  assign data_act = (acnt_q != dcnt_q);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    acnt_d   = acnt_q;
    dcnt_d   = dcnt_q;
    o_htrans = HT_IDLE;
    rvalid   = 1'b0;
    o_done   = 1'b0;
    o_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          base_d  = (WRAP_EN != 0) ? i_addr : (i_addr & ~IDX_MASK);
          acnt_d  = '0;
          dcnt_d  = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        o_htrans = (acnt_q == '0) ? HT_NONSEQ : HT_SEQ;
        if (data_act && i_hresp) begin
          if (i_hready) begin
            o_done  = 1'b1;
            o_err   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end else if (i_hready) begin
          acnt_d = acnt_q + CW'(1);
          if (data_act) begin
            rvalid = 1'b1;
            dcnt_d = dcnt_q + CW'(1);
          end
          if (acnt_q == LAST_CNT) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_hresp) begin
          if (i_hready) begin
            o_done  = 1'b1;
            o_err   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end else if (i_hready) begin
          rvalid  = 1'b1;
          dcnt_d  = dcnt_q + CW'(1);
          o_done  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (i_hready) begin
          o_done  = 1'b1;
          o_err   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  if (IW == 0) begin : g_ridx_single
    assign ridx = 1'b0;
  end else begin : g_ridx_line
    assign ridx = base_q[IDXW-1:0] + dcnt_q[IDXW-1:0];
  end

  assign o_busy      = (state_q != S_IDLE);
  assign o_rvalid    = rvalid;
  assign o_rdata     = rvalid ? i_hrdata : 32'd0;
  assign o_ridx      = ridx;
  assign o_haddr     = {word_at(base_q, acnt_q), 2'b00};
  assign o_hburst    = HBURST;
  assign o_hsize     = 3'h2;
  assign o_hwrite    = 1'b0;
  assign o_hprot     = 4'h1;
  assign o_hmastlock = 1'b0;
  assign o_hwdata    = 32'd0;

endmodule

// File: tb/tb_cache_ahb_refill_out.sv
// Bench for cache_ahb_refill_out: four configurations, each driven by a bus-level slave and
// checked against burst sequences computed arithmetically from the line geometry.
module tb_cache_ahb_refill_out;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [3:0]        req_v, hready_v, hresp_v;
  logic [2:0][29:0]  addr_v;
  logic [13:0]       addr3;
  logic [3:0][31:0]  hrdata_v;
  logic [3:0]        busy_v, rvalid_v, done_v, err_v, hwrite_v, hmastlock_v;
  logic [3:0][31:0]  rdata_v, haddr_v, hwdata_v;
  logic [3:0][1:0]   htrans_v;
  logic [3:0][2:0]   hburst_v, hsize_v;
  logic [3:0][3:0]   hprot_v, ridx_v;
  logic [1:0]        ridx0, ridx1;
  logic [0:0]        ridx2;
  logic [2:0]        ridx3;
  logic [15:0]       haddr3;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ridx_q[$];

  cache_ahb_refill_out #(.LINE_WORDS(4), .ADDR_W(32), .WRAP_EN(1)) u0 (
    .i_hclk(clk), .i_hnreset(rst_n), .i_req(req_v[0]), .i_addr(addr_v[0]),
    .o_busy(busy_v[0]), .o_rdata(rdata_v[0]), .o_rvalid(rvalid_v[0]), .o_ridx(ridx0),
    .o_done(done_v[0]), .o_err(err_v[0]), .o_haddr(haddr_v[0]), .o_htrans(htrans_v[0]),
    .o_hburst(hburst_v[0]), .o_hsize(hsize_v[0]), .o_hwrite(hwrite_v[0]), .o_hprot(hprot_v[0]),
    .o_hmastlock(hmastlock_v[0]), .o_hwdata(hwdata_v[0]), .i_hready(hready_v[0]),
    .i_hresp(hresp_v[0]), .i_hrdata(hrdata_v[0]));

  cache_ahb_refill_out #(.LINE_WORDS(4), .ADDR_W(32), .WRAP_EN(0)) u1 (
    .i_hclk(clk), .i_hnreset(rst_n), .i_req(req_v[1]), .i_addr(addr_v[1]),
    .o_busy(busy_v[1]), .o_rdata(rdata_v[1]), .o_rvalid(rvalid_v[1]), .o_ridx(ridx1),
    .o_done(done_v[1]), .o_err(err_v[1]), .o_haddr(haddr_v[1]), .o_htrans(htrans_v[1]),
    .o_hburst(hburst_v[1]), .o_hsize(hsize_v[1]), .o_hwrite(hwrite_v[1]), .o_hprot(hprot_v[1]),
    .o_hmastlock(hmastlock_v[1]), .o_hwdata(hwdata_v[1]), .i_hready(hready_v[1]),
    .i_hresp(hresp_v[1]), .i_hrdata(hrdata_v[1]));

  cache_ahb_refill_out #(.LINE_WORDS(1), .ADDR_W(32), .WRAP_EN(1)) u2 (
    .i_hclk(clk), .i_hnreset(rst_n), .i_req(req_v[2]), .i_addr(addr_v[2]),
    .o_busy(busy_v[2]), .o_rdata(rdata_v[2]), .o_rvalid(rvalid_v[2]), .o_ridx(ridx2),
    .o_done(done_v[2]), .o_err(err_v[2]), .o_haddr(haddr_v[2]), .o_htrans(htrans_v[2]),
    .o_hburst(hburst_v[2]), .o_hsize(hsize_v[2]), .o_hwrite(hwrite_v[2]), .o_hprot(hprot_v[2]),
    .o_hmastlock(hmastlock_v[2]), .o_hwdata(hwdata_v[2]), .i_hready(hready_v[2]),
    .i_hresp(hresp_v[2]), .i_hrdata(hrdata_v[2]));

  cache_ahb_refill_out #(.LINE_WORDS(8), .ADDR_W(16), .WRAP_EN(0)) u3 (
    .i_hclk(clk), .i_hnreset(rst_n), .i_req(req_v[3]), .i_addr(addr3),
    .o_busy(busy_v[3]), .o_rdata(rdata_v[3]), .o_rvalid(rvalid_v[3]), .o_ridx(ridx3),
    .o_done(done_v[3]), .o_err(err_v[3]), .o_haddr(haddr3), .o_htrans(htrans_v[3]),
    .o_hburst(hburst_v[3]), .o_hsize(hsize_v[3]), .o_hwrite(hwrite_v[3]), .o_hprot(hprot_v[3]),
    .o_hmastlock(hmastlock_v[3]), .o_hwdata(hwdata_v[3]), .i_hready(hready_v[3]),
    .i_hresp(hresp_v[3]), .i_hrdata(hrdata_v[3]));

  assign ridx_v[0]  = {2'b00, ridx0};
  assign ridx_v[1]  = {2'b00, ridx1};
  assign ridx_v[2]  = {3'b000, ridx2};
  assign ridx_v[3]  = {1'b0, ridx3};
  assign haddr_v[3] = {16'h0000, haddr3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lw_of(input int c);
    case (c)
      0, 1:    return 4;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit we_of(input int c);
    return (c == 0) || (c == 2);
  endfunction

  function automatic logic [31:0] burst_of(input int c);
    case (lw_of(c))
      1:       return 32'h0;
      4:       return we_of(c) ? 32'h2 : 32'h3;
      8:       return we_of(c) ? 32'h4 : 32'h5;
      default: return we_of(c) ? 32'h6 : 32'h7;
    endcase
  endfunction

  task automatic set_addr(input int c, input logic [29:0] a);
    if (c == 3) addr3 = a[13:0];
    else addr_v[c] = a;
  endtask

  task automatic check_reset_outs(input int c);
    check($sformatf("rst_htrans%0d", c), 32'(htrans_v[c]), 32'h0);
    check($sformatf("rst_haddr%0d", c), haddr_v[c], 32'h0);
    check($sformatf("rst_busy%0d", c), 32'(busy_v[c]), 32'h0);
    check($sformatf("rst_rvalid%0d", c), 32'(rvalid_v[c]), 32'h0);
    check($sformatf("rst_done%0d", c), 32'(done_v[c]), 32'h0);
    check($sformatf("rst_err%0d", c), 32'(err_v[c]), 32'h0);
  endtask

  // One refill on configuration c. err_k: data phase that gets a two-cycle ERROR response
  // (>= line size means none); stall_k/stall_n: extra wait states on that data phase;
  // abort_at: burst cycle at which reset is pulsed (-1 means never).
  task automatic run_refill(input int c, input logic [29:0] a_in, input int stall_k,
                            input int stall_n, input int err_k, input bit rnd, input int abort_at);
    int L, n_acc, n_done, stalls, n_rv;
    logic [31:0] a, idx, base, w;
    bit pend, aborted, err_first, err_now, fin, exp_rv, exp_done;
    L = lw_of(c);
    a = {2'b00, a_in};
    if (c == 3) a = a & 32'h3FFF;
    idx = a % L;
    base = a - idx;
    exp_q.delete();
    ridx_q.delete();
    for (int k = 0; k < L; k++) begin
      w = we_of(c) ? base + (idx + k) % L : base + k;
      exp_q.push_back(w * 4);
      ridx_q.push_back(w % L);
    end
    n_acc = 0; n_done = 0; stalls = 0; n_rv = 0;
    pend = 0; aborted = 0; err_first = 0; fin = 0;

    @(negedge clk);
    req_v[c] = 1'b1;
    set_addr(c, a[29:0]);
    hready_v[c] = 1'b1;
    hresp_v[c] = 1'b0;
    #1;
    check("idle_busy", 32'(busy_v[c]), 32'h0);
    check("idle_htrans", 32'(htrans_v[c]), 32'h0);
    check("idle_done", 32'(done_v[c]), 32'h0);
    @(posedge clk);

    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      req_v[c] = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      set_addr(c, 30'($urandom));
      hresp_v[c] = 1'b0;
      hrdata_v[c] = $urandom;
      err_now = 0;
      if (err_first) begin
        hready_v[c] = 1'b1; hresp_v[c] = 1'b1;
      end else if (pend && n_done == err_k) begin
        hready_v[c] = 1'b0; hresp_v[c] = 1'b1; err_now = 1;
      end else if (pend && n_done == stall_k && stalls < stall_n) begin
        hready_v[c] = 1'b0; stalls++;
      end else begin
        hready_v[c] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      check("busy", 32'(busy_v[c]), 32'h1);
      if (!aborted && n_acc < L) begin
        check("htrans", 32'(htrans_v[c]), (n_acc == 0) ? 32'h2 : 32'h3);
        check("haddr", haddr_v[c], exp_q[0]);
        check("hburst", 32'(hburst_v[c]), burst_of(c));
      end else begin
        check("htrans_idle", 32'(htrans_v[c]), 32'h0);
      end
      exp_rv = pend && hready_v[c] && !hresp_v[c];
      check("rvalid", 32'(rvalid_v[c]), 32'(exp_rv));
      check("rdata", rdata_v[c], exp_rv ? hrdata_v[c] : 32'h0);
      if (exp_rv) check("ridx", 32'(ridx_v[c]), ridx_q[0]);
      exp_done = err_first || (exp_rv && n_done == L - 1);
      check("done", 32'(done_v[c]), 32'(exp_done));
      check("err", 32'(err_v[c]), 32'(err_first));
      check("consts", {hwdata_v[c][15:0], 4'(hsize_v[c]), hprot_v[c], 3'b000, hwrite_v[c],
                       3'b000, hmastlock_v[c]}, 32'h0000_2100);
      n_rv += int'(rvalid_v[c]);
      if (cyc == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outs(c);
        req_v[c] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      if (err_now) begin
        aborted = 1; err_first = 1;
      end else if (err_first) begin
        fin = 1;
      end else if (hready_v[c]) begin
        if (pend) begin
          pend = 0; n_done++;
          void'(ridx_q.pop_front());
          if (n_done == L) fin = 1;
        end
        if (n_acc < L) begin
          n_acc++; pend = 1;
          void'(exp_q.pop_front());
        end
      end
    end
    check("finished", 32'(fin), 32'h1);
    check("rvalid_count", n_rv, (err_k < L) ? err_k : L);
    @(negedge clk);
    req_v[c] = 1'b0;
    hready_v[c] = 1'b1;
    hresp_v[c] = 1'b0;
    #1;
    check("after_busy", 32'(busy_v[c]), 32'h0);
    check("after_done", 32'(done_v[c]), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, L, ek, sk;
    rst_n = 1'b0;
    req_v = '0; hready_v = '1; hresp_v = '0; hrdata_v = '0; addr_v = '0; addr3 = '0;
    #12;
    for (int i = 0; i < 4; i++) check_reset_outs(i);
    @(negedge clk);
    rst_n = 1'b1;

    run_refill(0, 30'h6, -1, 0, 99, 0, -1);
    run_refill(1, 30'h6, -1, 0, 99, 0, -1);
    run_refill(0, 30'($urandom), 1, 3, 99, 0, -1);
    run_refill(0, 30'($urandom), -1, 0, 2, 0, -1);
    run_refill(0, 30'($urandom), -1, 0, 99, 0, 3);
    run_refill(0, 30'h6, -1, 0, 99, 0, -1);
    run_refill(2, 30'($urandom), -1, 0, 99, 0, -1);
    run_refill(2, 30'($urandom), -1, 0, 0, 0, -1);
    run_refill(3, 30'h3FFB, -1, 0, 99, 0, -1);
    run_refill(1, 30'($urandom), 3, 2, 3, 0, -1);

    for (int i = 0; i < 60; i++) begin
      c = $urandom_range(0, 3);
      L = lw_of(c);
      ek = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : 99;
      sk = $urandom_range(0, L - 1);
      run_refill(c, 30'($urandom), sk, $urandom_range(0, 3), ek, 1,
                 ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
